s_seq_buffer: RTL and testbench

On-chip query-sequence (s) buffer for the Smith-Waterman array. It takes a base-serial stream (2-bit bases, valid/ready), packs 64 bases per 128-bit word into a 256-word RAM and records the length. While `Top` is busy it replays the stored sequence chunk by chunk on each `o_request_s`, wrapping to the start after the last chunk. It sits directly upstream of `Top` and drives its `i_s` / `i_s_valid` inputs, replacing the preloaded s ROM.

---
 rtl/s_seq_buffer_if.sv | 36 +++
 rtl/s_seq_buffer.sv | 154 +++++++++++++++
 tb/tb_s_seq_buffer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s_seq_buffer_if.sv
// Bundle between the s buffer, its base-stream source and Top.
// slave = the buffer side, master = the driving side.
interface s_seq_buffer_if #(
  parameter int DEPTH_LOG = 8,
  parameter int PE_LOG    = 6
);
  localparam int LW = DEPTH_LOG + PE_LOG + 1;
  localparam int W  = 2 * (2 ** PE_LOG);

  logic          i_load_start;
  logic [1:0]    i_base;
  logic          i_base_valid;
  logic          i_base_last;
  logic          o_base_ready;
  logic          o_loaded;
  logic [LW-1:0] o_s_len;
  logic          o_overflow;
  logic          i_busy;
  logic          i_request_s;
  logic [W-1:0]  o_s;
  logic [PE_LOG:0] o_s_valid;

  modport slave (
    input  i_load_start, i_base, i_base_valid,
    input  i_base_last, i_busy, i_request_s,
    output o_base_ready, o_loaded, o_s_len,
    output o_overflow, o_s, o_s_valid
  );

  modport master (
    output i_load_start, i_base, i_base_valid,
    output i_base_last, i_busy, i_request_s,
    input  o_base_ready, o_loaded, o_s_len,
    input  o_overflow, o_s, o_s_valid
  );
endinterface

// File: rtl/s_seq_buffer.sv
// Query-sequence buffer: packs a 2-bit base stream into RAM words and
// replays it chunk by chunk to Top. Ports: clk, rst_n, bus (slave).
module s_seq_buffer #(
  parameter int DEPTH_LOG = 8,
  parameter int PE_LOG    = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  s_seq_buffer_if.slave  bus
);
  localparam int NB    = 2 ** PE_LOG;
  localparam int W     = 2 * NB;
  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam int LW    = DEPTH_LOG + PE_LOG + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [DEPTH_LOG-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]         acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 loaded_q, loaded_d;
  logic [DEPTH_LOG-1:0] rd_addr_q, rd_addr_d;
  logic [LW-1:0]        rem_q, rem_d;
  logic [PE_LOG:0]      sv_q, sv_d;

  logic [W-1:0]         mem [DEPTH];
  logic [W-1:0]         rd_data;
  logic                 we, re;
  logic [W-1:0]         wdata, acc_n;
  logic                 start, full;
  logic [PE_LOG-1:0]    slot;

  assign start = bus.i_load_start && !bus.i_busy;
  // Count never exceeds capacity, so the top bit alone flags "full".
  assign full  = cnt_q[LW-1];
  assign slot  = cnt_q[PE_LOG-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    len_d     = len_q;
    loaded_d  = loaded_q;
    rd_addr_d = rd_addr_q;
    rem_d     = rem_q;
    sv_d      = '0;
    we        = 1'b0;
    re        = 1'b0;
    acc_n     = acc_q;
    wdata     = acc_q;
    if (start) begin
      state_d   = LOAD;
      cnt_d     = '0;
      wr_addr_d = '0;
      acc_d     = '0;
      ovf_d     = 1'b0;
      loaded_d  = 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (bus.i_base_valid) begin
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              acc_n[{slot, 1'b0} +: 2] = bus.i_base;
              cnt_d = cnt_q + 1'b1;
              if ((&slot) || bus.i_base_last) begin
                we        = 1'b1;
                wdata     = acc_n;
                wr_addr_d = wr_addr_q + 1'b1;
                acc_d     = '0;
              end else begin
                acc_d = acc_n;
              end
            end
            if (bus.i_base_last) begin
              state_d   = READY;
              loaded_d  = 1'b1;
              len_d     = full ? cnt_q : cnt_q + 1'b1;
              rd_addr_d = '0;
              rem_d     = len_d;
            end
          end
        end
        READY: begin
          if (!bus.i_busy) begin
            rd_addr_d = '0;
            rem_d     = len_q;
          end else if (bus.i_request_s && sv_q == '0) begin
            re = 1'b1;
            if (rem_q <= LW'(NB)) begin
              sv_d      = rem_q[PE_LOG:0];
              rd_addr_d = '0;
              rem_d     = len_q;
            end else begin
              sv_d      = '1;
              rd_addr_d = rd_addr_q + 1'b1;
              rem_d     = rem_q - LW'(NB);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      len_q     <= '0;
      loaded_q  <= 1'b0;
      rd_addr_q <= '0;
      rem_q     <= '0;
      sv_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      len_q     <= len_d;
      loaded_q  <= loaded_d;
      rd_addr_q <= rd_addr_d;
      rem_q     <= rem_d;
      sv_q      <= sv_d;
    end
  end

  // Plain synchronous RAM so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr_q] <= wdata;
    if (re) rd_data <= mem[rd_addr_q];
  end

  assign bus.o_base_ready = (state_q == LOAD);
  assign bus.o_loaded     = loaded_q;
  assign bus.o_s_len      = len_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_s_valid    = sv_q;
  assign bus.o_s          = (sv_q != '0) ? rd_data : '0;
endmodule

// File: tb/tb_s_seq_buffer.sv
// Bench for s_seq_buffer: load scenarios from a table, chunk replay
// checked against a scoreboard, plus corner-case sequences.
module tb_s_seq_buffer;
  localparam int CAP = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  s_seq_buffer_if #(.DEPTH_LOG(8), .PE_LOG(6)) sif ();
  s_seq_buffer #(.DEPTH_LOG(8), .PE_LOG(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  typedef struct {
    int n;
    int pat;
    bit gaps;
    bit held;
    int nreq;
    int exp_len;
    bit exp_ovf;
  } vec_t;

  typedef struct {
    logic [6:0]   sv;
    logic [127:0] s;
  } exp_t;

  vec_t vecs[6];
  int checks = 0;
  int failures = 0;

  logic [1:0] sent [CAP];
  int m_len = 0;
  int m_rd = 0;
  int m_rem = 0;
  bit m_ready = 1'b0;
  bit m_pend = 1'b0;
  exp_t sb[$];
  logic [6:0]   got_sv[$];
  logic [127:0] got_s[$];

  function automatic logic [1:0] basef(int pat, int k);
    if (pat == 0) return 2'(k);
    return 2'((k * 7) ^ (k >> 3) ^ (k >> 6));
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock: model the request at this edge, then check outputs.
  task automatic step();
    bit acc;
    exp_t e;
    logic [127:0] w;
    int idx;
    acc = m_ready && sif.i_busy && sif.i_request_s && !m_pend;
    if (acc) begin
      w = '0;
      for (int j = 0; j < 64; j++) begin
        idx = m_rd * 64 + j;
        if (idx < m_len) w[2*j +: 2] = sent[idx];
      end
      e.s = w;
      if (m_rem <= 64) begin
        e.sv  = 7'(m_rem);
        m_rd  = 0;
        m_rem = m_len;
      end else begin
        e.sv  = 7'd127;
        m_rd  = m_rd + 1;
        m_rem = m_rem - 64;
      end
      sb.push_back(e);
    end else if (m_ready && !sif.i_busy) begin
      m_rd  = 0;
      m_rem = m_len;
    end
    @(posedge clk);
    #1;
    m_pend = acc;
    if (m_pend) begin
      e = sb.pop_front();
      chk("s_valid", 128'(sif.o_s_valid), 128'(e.sv));
      chk("s_data", sif.o_s, e.s);
      got_sv.push_back(sif.o_s_valid);
      got_s.push_back(sif.o_s);
    end else begin
      chk("idle_s_valid", 128'(sif.o_s_valid), 128'd0);
      chk("idle_s", sif.o_s, 128'd0);
    end
  endtask

  task automatic load(int n, int pat, bit gaps, int exp_len, bit exp_ovf);
    int k;
    sif.i_busy = 1'b0;
    sif.i_load_start = 1'b1;
    step();
    sif.i_load_start = 1'b0;
    m_ready = 1'b0;
    chk("ready_after_start", 128'(sif.o_base_ready), 128'd1);
    chk("loaded_cleared", 128'(sif.o_loaded), 128'd0);
    chk("ovf_cleared", 128'(sif.o_overflow), 128'd0);
    k = 0;
    while (k < n) begin
      sif.i_base_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      sif.i_base_last = 1'b0;
      if (sif.i_base_valid) begin
        sif.i_base = basef(pat, k);
        sif.i_base_last = (k == n - 1);
        if (k < CAP) sent[k] = sif.i_base;
        if (k == n - 1)
          chk("ready_before_last", 128'(sif.o_base_ready), 128'd1);
        k++;
      end
      step();
    end
    sif.i_base_valid = 1'b0;
    sif.i_base_last = 1'b0;
    m_len = exp_len;
    m_rd = 0;
    m_rem = exp_len;
    m_ready = 1'b1;
    chk("ready_after_last", 128'(sif.o_base_ready), 128'd0);
    chk("loaded", 128'(sif.o_loaded), 128'd1);
    chk("s_len", 128'(sif.o_s_len), 128'(exp_len));
    chk("overflow", 128'(sif.o_overflow), 128'(exp_ovf));
  endtask

  task automatic serve(bit held, int n);
    got_sv.delete();
    got_s.delete();
    sif.i_busy = 1'b1;
    step();
    if (held) begin
      sif.i_request_s = 1'b1;
      repeat (n) step();
      sif.i_request_s = 1'b0;
    end else begin
      repeat (n) begin
        sif.i_request_s = 1'b1;
        step();
        sif.i_request_s = 1'b0;
        step();
        step();
      end
    end
    step();
    step();
  endtask

  task automatic idle_busy();
    sif.i_busy = 1'b0;
    step();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready"}, 128'(sif.o_base_ready), 128'd0);
    chk({tag, "_loaded"}, 128'(sif.o_loaded), 128'd0);
    chk({tag, "_len"}, 128'(sif.o_s_len), 128'd0);
    chk({tag, "_ovf"}, 128'(sif.o_overflow), 128'd0);
    chk({tag, "_s"}, sif.o_s, 128'd0);
    chk({tag, "_sv"}, 128'(sif.o_s_valid), 128'd0);
  endtask

  initial begin
    vecs[0] = '{n: 130,   pat: 1, gaps: 1, held: 0, nreq: 4,
                exp_len: 130, exp_ovf: 0};
    vecs[1] = '{n: 64,    pat: 0, gaps: 0, held: 0, nreq: 3,
                exp_len: 64, exp_ovf: 0};
    vecs[2] = '{n: 200,   pat: 1, gaps: 0, held: 1, nreq: 10,
                exp_len: 200, exp_ovf: 0};
    vecs[3] = '{n: 16385, pat: 1, gaps: 0, held: 1, nreq: 514,
                exp_len: 16384, exp_ovf: 1};
    vecs[4] = '{n: 1,     pat: 1, gaps: 1, held: 0, nreq: 2,
                exp_len: 1, exp_ovf: 0};
    vecs[5] = '{n: 65,    pat: 1, gaps: 0, held: 0, nreq: 3,
                exp_len: 65, exp_ovf: 0};

    sif.i_load_start = 1'b0;
    sif.i_base = 2'd0;
    sif.i_base_valid = 1'b0;
    sif.i_base_last = 1'b0;
    sif.i_busy = 1'b0;
    sif.i_request_s = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load(vecs[i].n, vecs[i].pat, vecs[i].gaps,
           vecs[i].exp_len, vecs[i].exp_ovf);
      serve(vecs[i].held, vecs[i].nreq);
      if (vecs[i].n > CAP)
        chk("ovf_last_chunk_sv", 128'(got_sv[255]), 128'd64);
      idle_busy();
    end

    // 130 bases k mod 4: fixed chunk pattern and wrap.
    load(130, 0, 0, 130, 0);
    serve(0, 4);
    chk("t1_sv0", 128'(got_sv[0]), 128'd127);
    chk("t1_sv1", 128'(got_sv[1]), 128'd127);
    chk("t1_sv2", 128'(got_sv[2]), 128'd2);
    chk("t1_sv3", 128'(got_sv[3]), 128'd127);
    chk("t1_w0", got_s[0], {16{8'hE4}});
    chk("t1_w1", got_s[1], {16{8'hE4}});
    chk("t1_w2", got_s[2], 128'h4);
    chk("t1_w0_again", got_s[3], {16{8'hE4}});
    idle_busy();

    // Held request: data every other cycle.
    load(200, 0, 0, 200, 0);
    serve(1, 10);
    chk("t3_cnt", 128'(got_sv.size()), 128'd5);
    chk("t3_sv0", 128'(got_sv[0]), 128'd127);
    chk("t3_sv1", 128'(got_sv[1]), 128'd127);
    chk("t3_sv2", 128'(got_sv[2]), 128'd127);
    chk("t3_sv3", 128'(got_sv[3]), 128'd8);
    chk("t3_sv4", 128'(got_sv[4]), 128'd127);
    idle_busy();

    // Busy drop for one cycle rewinds the read pointer.
    load(200, 1, 0, 200, 0);
    serve(0, 2);
    sif.i_busy = 1'b0;
    step();
    sif.i_busy = 1'b1;
    step();
    sif.i_request_s = 1'b1;
    step();
    sif.i_request_s = 1'b0;
    chk("t4_sv", 128'(sif.o_s_valid), 128'd127);
    chk("t4_w0", sif.o_s, got_s[0]);
    step();

    // Load start while busy in READY is ignored.
    sif.i_load_start = 1'b1;
    step();
    sif.i_load_start = 1'b0;
    chk("busy_start_ready", 128'(sif.o_base_ready), 128'd0);
    chk("busy_start_loaded", 128'(sif.o_loaded), 128'd1);
    idle_busy();

    // Restart in the middle of a load discards the partial word.
    sif.i_load_start = 1'b1;
    step();
    sif.i_load_start = 1'b0;
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sif.i_base_valid = 1'b1;
      sif.i_base = 2'd3;
      step();
    end
    sif.i_base_valid = 1'b0;
    load(70, 1, 0, 70, 0);
    serve(0, 3);
    idle_busy();

    // Asynchronous reset mid-load.
    sif.i_load_start = 1'b1;
    step();
    sif.i_load_start = 1'b0;
    m_ready = 1'b0;
    sif.i_base_valid = 1'b1;
    repeat (5) step();
    sif.i_base_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    m_pend = 1'b0;
    m_len = 0;
    sb.delete();
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sif.i_busy = 1'b1;
    sif.i_load_start = 1'b1;
    step();
    sif.i_load_start = 1'b0;
    chk("rst_busy_start_ready", 128'(sif.o_base_ready), 128'd0);
    chk("rst_busy_start_loaded", 128'(sif.o_loaded), 128'd0);
    idle_busy();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
